bk_ram_sd: RTL and testbench

Backup-RAM transfer controller that moves cartridge save RAM to and from the mounted save image over the HPS sector interface (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`). It sits between `hps_io` and the cart RAM port.

- **Save:** reads cart RAM byte-wise, packs it into 512-byte sectors and issues sector writes.
- **Load:** issues sector reads and unpacks the received sectors into cart RAM.

It is the reader/uploader counterpart to the ROM download writer path. A local 256×16 sector buffer decouples HPS timing from RAM timing.

---
 rtl/bk_ram_sd.sv | 213 +++++++++++++++++++++
 tb/tb_bk_ram_sd.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_ram_sd.sv
// Backup-RAM transfer controller: moves cart save RAM to/from the mounted save image
// through a 256x16 sector buffer sitting between the HPS sector port and the cart RAM port.
module bk_ram_sd #(
    parameter int ADDR_W = 17,
    parameter int SEC_W  = ADDR_W - 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bk_load,
    input  logic              bk_save,
    input  logic              bk_ena,
    input  logic [SEC_W-1:0]  ram_sectors,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [7:0]        sd_buff_addr,
    input  logic [15:0]       sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [15:0]       sd_buff_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              loading,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WREQ, S_WACK, S_RREQ, S_RACK, S_DRAIN, S_NEXT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SEC_W-1:0]   r_sec, r_count, w_sec_nxt, w_sec_inc;
    logic               r_is_load, w_is_load_nxt;
    logic [9:0]         r_cnt;
    logic [7:0]         r_lo;
    logic [15:0]        r_buf [0:255];
    logic               w_req_ok, w_start_load, w_start_save;
    logic [8:0]         w_fill_off;
    logic [7:0]         w_fill_idx;
    logic [15:0]        w_drain_word;
    logic [7:0]         w_drain_byte;
    logic [ADDR_W-1:0]  w_ram_addr_nxt;
    logic               w_buf_we;
    logic [7:0]         w_buf_idx;
    logic [15:0]        w_buf_wdata;

    logic [31:0]        r_sd_lba;
    logic               r_sd_rd, r_sd_wr, r_ram_we, r_busy, r_loading, r_done;
    logic [15:0]        r_sd_buff_din;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [7:0]         r_ram_wdata;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [SEC_W-1:0] sec, input logic [8:0] off);
        return ADDR_W'({sec, off});
    endfunction

    assign w_req_ok     = bk_ena && (ram_sectors != {SEC_W{1'b0}});
    assign w_start_load = w_req_ok && bk_load;
    assign w_start_save = w_req_ok && bk_save && !bk_load;
    assign w_sec_inc    = r_sec + SEC_W'(1'b1);
    assign w_fill_off   = r_cnt[8:0] + 9'd1;
    // Byte c-1 arrives at FILL cycle c; odd bytes complete word (c-1)>>1, which wraps to 255 at c=512.
    assign w_fill_idx   = r_cnt[8:1] - 8'd1;
    assign w_drain_word = r_buf[r_cnt[8:1]];
    assign w_drain_byte = r_cnt[0] ? w_drain_word[15:8] : w_drain_word[7:0];

    // Next-state and next-sector selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_sec_nxt     = r_sec;
        w_is_load_nxt = r_is_load;
        case (r_state)
            S_IDLE: begin
                if (w_start_load) begin
                    w_state_nxt   = S_RREQ;
                    w_sec_nxt     = {SEC_W{1'b0}};
                    w_is_load_nxt = 1'b1;
                end else if (w_start_save) begin
                    w_state_nxt   = S_FILL;
                    w_sec_nxt     = {SEC_W{1'b0}};
                    w_is_load_nxt = 1'b0;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_FILL:  w_state_nxt = (r_cnt == 10'd512) ? S_WREQ  : S_FILL;
            S_WREQ:  w_state_nxt = sd_ack ? S_WACK : S_WREQ;
            S_WACK:  w_state_nxt = sd_ack ? S_WACK : S_NEXT;
            S_RREQ:  w_state_nxt = sd_ack ? S_RACK : S_RREQ;
            S_RACK:  w_state_nxt = sd_ack ? S_RACK : S_DRAIN;
            S_DRAIN: w_state_nxt = (r_cnt == 10'd512) ? S_NEXT : S_DRAIN;
            S_NEXT: begin
                w_sec_nxt = w_sec_inc;
                if (w_sec_inc == r_count) begin
                    w_state_nxt = S_IDLE;
                end else if (r_is_load) begin
                    w_state_nxt = S_RREQ;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Cart RAM address for the next cycle: FILL issues one address ahead, DRAIN follows the buffer read.
    always_comb begin
        w_ram_addr_nxt = r_ram_addr;
        if (w_state_nxt == S_FILL && r_state != S_FILL) begin
            w_ram_addr_nxt = f_addr(w_sec_nxt, 9'd0);
        end else if (r_state == S_FILL && r_cnt < 10'd511) begin
            w_ram_addr_nxt = f_addr(r_sec, w_fill_off);
        end else if (r_state == S_DRAIN && !r_cnt[9]) begin
            w_ram_addr_nxt = f_addr(r_sec, r_cnt[8:0]);
        end else begin
            w_ram_addr_nxt = r_ram_addr;
        end
    end

    // Buffer write port shared by HPS load data and packed cart RAM bytes.
    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_idx   = 8'd0;
        w_buf_wdata = 16'd0;
        if (r_state == S_RACK && sd_ack && sd_buff_wr) begin
            w_buf_we    = 1'b1;
            w_buf_idx   = sd_buff_addr;
            w_buf_wdata = sd_buff_dout;
        end else if (r_state == S_FILL && r_cnt != 10'd0 && !r_cnt[0]) begin
            w_buf_we    = 1'b1;
            w_buf_idx   = w_fill_idx;
            w_buf_wdata = {ram_rdata, r_lo};
        end else begin
            w_buf_we    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Sector index, latched count, direction, byte counter and low-byte holding register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sec     <= {SEC_W{1'b0}};
            r_count   <= {SEC_W{1'b0}};
            r_is_load <= 1'b0;
            r_cnt     <= 10'd0;
            r_lo      <= 8'd0;
        end else begin
            r_sec     <= w_sec_nxt;
            r_is_load <= w_is_load_nxt;
            if (r_state == S_IDLE && (w_start_load || w_start_save)) r_count <= ram_sectors;
            else                                                     r_count <= r_count;
            if ((r_state == S_FILL || r_state == S_DRAIN) && w_state_nxt == r_state) r_cnt <= r_cnt + 10'd1;
            else                                                                      r_cnt <= 10'd0;
            if (r_state == S_FILL && r_cnt[0]) r_lo <= ram_rdata;
            else                               r_lo <= r_lo;
        end
    end

    // Sector buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk_sys) begin
        if (w_buf_we) r_buf[w_buf_idx] <= w_buf_wdata;
    end

    // Registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sd_lba      <= 32'd0;
            r_sd_rd       <= 1'b0;
            r_sd_wr       <= 1'b0;
            r_sd_buff_din <= 16'd0;
            r_ram_addr    <= {ADDR_W{1'b0}};
            r_ram_wdata   <= 8'd0;
            r_ram_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_loading     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_sd_rd    <= (w_state_nxt == S_RREQ);
            r_sd_wr    <= (w_state_nxt == S_WREQ);
            if (w_state_nxt == S_RREQ || w_state_nxt == S_WREQ) r_sd_lba <= {{(32-SEC_W){1'b0}}, w_sec_nxt};
            else                                                 r_sd_lba <= r_sd_lba;
            if (r_state == S_WREQ || r_state == S_WACK) r_sd_buff_din <= r_buf[sd_buff_addr];
            else                                        r_sd_buff_din <= r_sd_buff_din;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_we   <= (r_state == S_DRAIN) && !r_cnt[9];
            if (r_state == S_DRAIN && !r_cnt[9]) r_ram_wdata <= w_drain_byte;
            else                                 r_ram_wdata <= r_ram_wdata;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_loading  <= (w_state_nxt != S_IDLE) && w_is_load_nxt;
            r_done     <= (w_state_nxt == S_NEXT) && (w_sec_inc == r_count);
        end
    end

    assign sd_lba      = r_sd_lba;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_buff_din = r_sd_buff_din;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign ram_we      = r_ram_we;
    assign busy        = r_busy;
    assign loading     = r_loading;
    assign done        = r_done;

endmodule

// File: tb/tb_bk_ram_sd.sv
// Directed self-checking bench for bk_ram_sd with a synchronous cart RAM model and a scripted HPS.
module tb_bk_ram_sd;
    localparam int ADDR_W = 17;
    localparam int SEC_W  = ADDR_W - 8;

    logic              clk_sys = 1'b0;
    logic              reset, bk_load, bk_save, bk_ena, sd_ack, sd_buff_wr;
    logic [SEC_W-1:0]  ram_sectors;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr, ram_we, busy, loading, done;
    logic [7:0]        sd_buff_addr, ram_wdata, ram_rdata;
    logic [15:0]       sd_buff_dout, sd_buff_din;
    logic [ADDR_W-1:0] ram_addr;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic       use_pattern, mon_clr, load_phase;
    int         we_cnt, done_cnt, rd_cnt, wr_cnt, load_drop;
    int         n_pass = 0, n_total = 0;

    always #5 clk_sys = ~clk_sys;

    bk_ram_sd #(.ADDR_W(ADDR_W), .SEC_W(SEC_W)) dut (
        .clk_sys(clk_sys), .reset(reset), .bk_load(bk_load), .bk_save(bk_save), .bk_ena(bk_ena),
        .ram_sectors(ram_sectors), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy), .loading(loading), .done(done)
    );

    // Cart RAM: synchronous read; in pattern mode each byte equals its low address bits.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= use_pattern ? ram_addr[7:0] : mem[ram_addr];
    end

    always @(negedge clk_sys) begin
        if (mon_clr) begin
            we_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; load_drop = 0;
        end else begin
            if (ram_we === 1'b1) we_cnt++;
            if (done === 1'b1) done_cnt++;
            if (sd_rd === 1'b1) rd_cnt++;
            if (sd_wr === 1'b1) wr_cnt++;
            if (load_phase && busy === 1'b1 && loading !== 1'b1) load_drop++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return sd_rd;
            1:       return sd_wr;
            2:       return done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int budget);
        int k = 0;
        while (sel_sig(sel) !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(sel_sig(sel)), 32'd1);
    endtask

    // One HPS sector read: ack, stream 256 words 16'hA000+w, drop ack.
    task automatic hps_load_sector();
        sd_ack = 1'b1;
        step();
        chk("rd_drop_after_ack", 32'(sd_rd), 32'd0);
        for (int w = 0; w < 256; w++) begin
            sd_buff_addr = 8'(w);
            sd_buff_dout = 16'(16'hA000 + w);
            sd_buff_wr   = 1'b1;
            step();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        step();
    endtask

    initial begin
        logic [15:0] exp_din;
        reset = 1'b1; bk_load = 1'b0; bk_save = 1'b0; bk_ena = 1'b0; ram_sectors = '0;
        sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
        use_pattern = 1'b0; mon_clr = 1'b1; load_phase = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_buff_din", 32'(sd_buff_din), 32'd0);
        reset = 1'b0;
        mon_clr = 1'b0;
        step();

        // Save, 1 sector
        use_pattern = 1'b1; bk_ena = 1'b1; ram_sectors = 9'd1;
        clr_mon();
        bk_save = 1'b1;
        step();
        bk_save = 1'b0;
        chk("save_busy_latency", 32'(busy), 32'd1);
        chk("save_no_wr_in_fill", 32'(sd_wr), 32'd0);
        wait_for("save_wr_seen", 1, 700);
        chk("save_lba", sd_lba, 32'd0);
        sd_ack = 1'b1;
        step();
        chk("save_wr_drop", 32'(sd_wr), 32'd0);
        for (int a = 0; a < 256; a++) begin
            sd_buff_addr = 8'(a);
            step();
            exp_din = {8'((2*a+1) & 255), 8'((2*a) & 255)};
            chk("save_buff_din", 32'(sd_buff_din), 32'(exp_din));
        end
        sd_buff_addr = 8'd3;
        step();
        chk("save_din_addr3", 32'(sd_buff_din), 32'h0706);
        sd_ack = 1'b0;
        step();
        chk("save_done", 32'(done), 32'd1);
        chk("save_busy_at_done", 32'(busy), 32'd1);
        step();
        chk("save_done_drop", 32'(done), 32'd0);
        chk("save_busy_drop", 32'(busy), 32'd0);
        chk("save_done_count", 32'(done_cnt), 32'd1);

        // Load, 2 sectors
        use_pattern = 1'b0; ram_sectors = 9'd2; load_phase = 1'b1;
        clr_mon();
        bk_load = 1'b1;
        step();
        bk_load = 1'b0;
        chk("load_rd_latency", 32'(sd_rd), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_loading", 32'(loading), 32'd1);
        chk("load_lba0", sd_lba, 32'd0);
        hps_load_sector();
        wait_for("load_rd_sec1", 0, 700);
        chk("load_lba1", sd_lba, 32'd1);
        hps_load_sector();
        wait_for("load_done", 2, 700);
        chk("load_loading_at_done", 32'(loading), 32'd1);
        step();
        chk("load_busy_drop", 32'(busy), 32'd0);
        chk("load_loading_drop", 32'(loading), 32'd0);
        load_phase = 1'b0;
        chk("load_mem0", 32'(mem[0]), 32'h00);
        chk("load_mem5", 32'(mem[5]), 32'hA0);
        chk("load_mem4", 32'(mem[4]), 32'h02);
        chk("load_mem512", 32'(mem[512]), 32'h00);
        chk("load_mem513", 32'(mem[513]), 32'hA0);
        chk("load_mem1022", 32'(mem[1022]), 32'hFF);
        chk("load_we_count", 32'(we_cnt), 32'd1024);
        chk("load_loading_steady", 32'(load_drop), 32'd0);
        chk("load_done_count", 32'(done_cnt), 32'd1);

        // Simultaneous requests: load wins
        ram_sectors = 9'd1;
        clr_mon();
        bk_load = 1'b1; bk_save = 1'b1;
        step();
        bk_load = 1'b0; bk_save = 1'b0;
        chk("both_rd", 32'(sd_rd), 32'd1);
        chk("both_no_wr", 32'(sd_wr), 32'd0);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        wait_for("both_done", 2, 700);
        step();
        chk("both_wr_never", 32'(wr_cnt), 32'd0);

        // Gating
        bk_ena = 1'b0; ram_sectors = 9'd1;
        clr_mon();
        bk_save = 1'b1; bk_load = 1'b1;
        step(); step();
        chk("gate_ena_busy", 32'(busy), 32'd0);
        bk_save = 1'b0; bk_load = 1'b0; bk_ena = 1'b1; ram_sectors = 9'd0;
        bk_load = 1'b1;
        step(); step();
        chk("gate_zero_load_busy", 32'(busy), 32'd0);
        bk_load = 1'b0; bk_save = 1'b1;
        step(); step();
        chk("gate_zero_save_busy", 32'(busy), 32'd0);
        bk_save = 1'b0;
        step();
        chk("gate_no_done", 32'(done_cnt), 32'd0);
        chk("gate_no_rd", 32'(rd_cnt), 32'd0);

        // Requests while busy are ignored and the latched count holds
        ram_sectors = 9'd1; use_pattern = 1'b1;
        clr_mon();
        bk_save = 1'b1;
        step();
        bk_save = 1'b0; ram_sectors = 9'd3; bk_load = 1'b1;
        repeat (5) step();
        bk_load = 1'b0;
        wait_for("busy_ign_wr", 1, 700);
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        step();
        chk("busy_ign_done", 32'(done), 32'd1);
        step();
        chk("busy_ign_idle", 32'(busy), 32'd0);
        chk("busy_ign_no_rd", 32'(rd_cnt), 32'd0);

        // Reset during RACK of sector 1 of 4
        use_pattern = 1'b0; ram_sectors = 9'd4; load_phase = 1'b1;
        clr_mon();
        bk_load = 1'b1;
        step();
        bk_load = 1'b0;
        hps_load_sector();
        wait_for("rst_mid_rd1", 0, 700);
        chk("rst_mid_lba1", sd_lba, 32'd1);
        sd_ack = 1'b1;
        step();
        for (int w = 0; w < 10; w++) begin
            sd_buff_addr = 8'(w); sd_buff_dout = 16'(16'h5500 + w); sd_buff_wr = 1'b1;
            step();
        end
        reset = 1'b1;
        #1;
        load_phase = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_loading", 32'(loading), 32'd0);
        chk("rst_mid_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_mid_sd_lba", sd_lba, 32'd0);
        chk("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_mid_ram_we", 32'(ram_we), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        clr_mon();
        for (int w = 0; w < 8; w++) begin
            sd_buff_addr = 8'(w); sd_buff_wr = 1'b1;
            step();
        end
        sd_buff_wr = 1'b0; sd_ack = 1'b0;
        repeat (3) step();
        chk("rst_mid_no_we", 32'(we_cnt), 32'd0);
        chk("rst_mid_idle", 32'(busy), 32'd0);

        // Ack already high on entry to RREQ
        ram_sectors = 9'd1; sd_ack = 1'b1;
        clr_mon();
        bk_load = 1'b1;
        step();
        bk_load = 1'b0;
        chk("ackhi_rd_on", 32'(sd_rd), 32'd1);
        step();
        chk("ackhi_rd_off", 32'(sd_rd), 32'd0);
        repeat (4) step();
        chk("ackhi_no_drain", 32'(ram_we), 32'd0);
        sd_ack = 1'b0;
        step();
        chk("ackhi_drain_c0", 32'(ram_we), 32'd0);
        step();
        chk("ackhi_drain_c1", 32'(ram_we), 32'd1);
        wait_for("ackhi_done", 2, 700);
        step();
        chk("ackhi_we_count", 32'(we_cnt), 32'd512);
        chk("ackhi_rd_cycles", 32'(rd_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
